// File: rtl/fp_sub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_sub_seq_if
// Request/response bundle for the sequential single-precision subtractor.
//
// Signals
//   start      requester -> unit   one-cycle request, sampled only in IDLE
//   a_operand  requester -> unit   minuend (IEEE-754 single)
//   b_operand  requester -> unit   subtrahend (IEEE-754 single)
//   op         requester -> unit   only with FP_ADDSUB_OP_EN: 1 = add, 0 = subtract
//   busy       unit -> requester   high whenever the unit is not IDLE
//   done       unit -> requester   one-cycle pulse, result/Exception valid
//   result     unit -> requester   IEEE-754 result, held until next request
//   Exception  unit -> requester   special-operand / overflow flag
//
// Modports: master (requester side), slave (the arithmetic unit).
// Optional feature macro: FP_ADDSUB_OP_EN.
// ---------------------------------------------------------------------------
interface fp_sub_seq_if;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
`ifdef FP_ADDSUB_OP_EN
  logic        op;
`endif
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        Exception;

`ifdef FP_ADDSUB_OP_EN
  modport master (
    output start, a_operand, b_operand, op,
    input  busy, done, result, Exception
  );
  modport slave (
    input  start, a_operand, b_operand, op,
    output busy, done, result, Exception
  );
`else
  modport master (
    output start, a_operand, b_operand,
    input  busy, done, result, Exception
  );
  modport slave (
    input  start, a_operand, b_operand,
    output busy, done, result, Exception
  );
`endif
endinterface

// File: rtl/fp_sub_seq.sv
// ---------------------------------------------------------------------------
// fp_sub_seq
// Multi-cycle IEEE-754 single-precision subtractor: result = a - b.
// Alignment and normalisation proceed one bit per clock; rounding is pure
// truncation, denormal inputs are flushed to zero, Inf/NaN inputs produce
// +Inf with Exception set.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, aborts any operation
//   bus    slave modport of fp_sub_seq_if (start/operands in,
//          busy/done/result/Exception out)
//
// Optional feature macro: FP_ADDSUB_OP_EN
//   When defined, bus.op selects the operation (1 = a+b, 0 = a-b).
//   When undefined the unit always subtracts.
//
// Latency (edges after the edge that accepts start, until done is high):
//   special operand 1, zero result 3+d, otherwise 3+d+n
//   (d = saturated exponent difference, n = normalisation shifts).
// ---------------------------------------------------------------------------
module fp_sub_seq (
  input  logic         clk,
  input  logic         rst_n,
  fp_sub_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic [31:0] INF_RESULT = 32'h7F80_0000;
  localparam logic [4:0]  MAX_SHIFT  = 5'd25;

  state_t      state_q;
  // Captured operands; b_q already carries the effective (possibly flipped) sign.
  logic [31:0] a_q;
  logic [31:0] b_q;
  // Working datapath after the swap: A is the larger magnitude.
  logic        sign_a_q;
  logic        sign_b_q;
  logic [7:0]  exp_q;
  logic [24:0] mant_a_q;   // bit 24 catches the carry of a same-sign add
  logic [23:0] mant_b_q;
  logic [4:0]  shift_q;    // remaining alignment shifts
  // Registered outputs.
  logic [31:0] result_q;
  logic        exc_q;
  logic        busy_q;
  logic        done_q;

  // ------------------------------------------------------------------
  // Effective-operation select: flip b's sign for subtraction.
  // ------------------------------------------------------------------
  logic flip_b_d;
`ifdef FP_ADDSUB_OP_EN
  assign flip_b_d = ~bus.op;
`else
  assign flip_b_d = 1'b1;
`endif

  // ------------------------------------------------------------------
  // Unpack / swap network, evaluated from the captured operands while
  // the FSM sits in UNPACK.
  // ------------------------------------------------------------------
  logic [7:0]  exp_a_raw_d;
  logic [7:0]  exp_b_raw_d;
  logic [23:0] man_a_d;
  logic [23:0] man_b_d;
  logic        special_d;
  logic        a_ge_b_d;
  logic        big_sign_d;
  logic        small_sign_d;
  logic [7:0]  big_exp_d;
  logic [7:0]  small_exp_d;
  logic [23:0] big_man_d;
  logic [23:0] small_man_d;
  logic [7:0]  diff_d;
  logic [4:0]  shift_d;

  always_comb begin
    exp_a_raw_d = a_q[30:23];
    exp_b_raw_d = b_q[30:23];
    // Exponent 0 means zero or denormal: both become a true zero with no
    // hidden bit.
    man_a_d = (exp_a_raw_d == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    man_b_d = (exp_b_raw_d == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    special_d = (&exp_a_raw_d) | (&exp_b_raw_d);
    // Ties keep a in the A slot; for equal magnitudes the subtraction
    // yields zero either way.
    a_ge_b_d = {exp_a_raw_d, man_a_d} >= {exp_b_raw_d, man_b_d};
    if (a_ge_b_d) begin
      big_sign_d   = a_q[31];
      big_exp_d    = exp_a_raw_d;
      big_man_d    = man_a_d;
      small_sign_d = b_q[31];
      small_exp_d  = exp_b_raw_d;
      small_man_d  = man_b_d;
    end else begin
      big_sign_d   = b_q[31];
      big_exp_d    = exp_b_raw_d;
      big_man_d    = man_b_d;
      small_sign_d = a_q[31];
      small_exp_d  = exp_a_raw_d;
      small_man_d  = man_a_d;
    end
    diff_d = big_exp_d - small_exp_d;
    // Beyond 25 positions the smaller mantissa is already fully shifted out.
    shift_d = (diff_d > {3'd0, MAX_SHIFT}) ? MAX_SHIFT : diff_d[4:0];
  end

  // ------------------------------------------------------------------
  // Mantissa adder. A's magnitude is never below B's after the swap and
  // alignment, so the difference cannot go negative.
  // ------------------------------------------------------------------
  logic [24:0] sum_d;

  always_comb begin
    if (sign_a_q == sign_b_q) begin
      sum_d = {1'b0, mant_a_q[23:0]} + {1'b0, mant_b_q};
    end else begin
      sum_d = {1'b0, mant_a_q[23:0]} - {1'b0, mant_b_q};
    end
  end

  // ------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= 8'd0;
      mant_a_q <= 25'd0;
      mant_b_q <= 24'd0;
      shift_q  <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_operand;
            b_q     <= {bus.b_operand[31] ^ flip_b_d, bus.b_operand[30:0]};
            busy_q  <= 1'b1;
            state_q <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (special_d) begin
            result_q <= INF_RESULT;
            exc_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            sign_a_q <= big_sign_d;
            sign_b_q <= small_sign_d;
            exp_q    <= big_exp_d;
            mant_a_q <= {1'b0, big_man_d};
            mant_b_q <= small_man_d;
            shift_q  <= shift_d;
            state_q  <= (shift_d != 5'd0) ? S_ALIGN : S_ADD;
          end
        end

        S_ALIGN: begin
          // Shifted-out bits are dropped: no guard/round/sticky.
          mant_b_q <= mant_b_q >> 1;
          shift_q  <= shift_q - 5'd1;
          if (shift_q == 5'd1) begin
            state_q <= S_ADD;
          end
        end

        S_ADD: begin
          mant_a_q <= sum_d;
          state_q  <= S_NORM;
        end

        S_NORM: begin
          if (mant_a_q == 25'd0) begin
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (mant_a_q[24]) begin
            if (exp_q == 8'd254) begin
              result_q <= {sign_a_q, 8'hFF, 23'd0};
              exc_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              mant_a_q <= mant_a_q >> 1;
              exp_q    <= exp_q + 8'd1;
            end
          end else if (!mant_a_q[23]) begin
            if (exp_q == 8'd1) begin
              // Would go denormal: flush to a signed zero.
              result_q <= {sign_a_q, 31'd0};
              exc_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              mant_a_q <= mant_a_q << 1;
              exp_q    <= exp_q - 8'd1;
            end
          end else begin
            result_q <= {sign_a_q, exp_q, mant_a_q[22:0]};
            exc_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.Exception = exc_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_sub_seq
// Self-checking bench for fp_sub_seq: a table of hand-derived vectors with
// expected result/Exception/latency, a scoreboard queue filled at request
// time and drained on done, plus hand-written handshake and reset sequences.
// ---------------------------------------------------------------------------
module tb_fp_sub_seq;

  logic clk;
  logic rst_n;

  fp_sub_seq_if bus ();

  fp_sub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // mode 0: plain request.
  // mode 1: also pulse start while busy and during DONE, then watch for
  //         any spurious second done.
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input int el, input int mode);
    exp_t        e;
    exp_t        got;
    logic [31:0] held;
    bit          moved;
    bit          seen;
    bit          spurious;
    int          cnt;
    e.res = er;
    e.exc = ee;
    e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    held          = bus.result;
    moved         = 1'b0;
    bus.a_operand = a;
    bus.b_operand = b;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    // Operands are free to change once accepted.
    bus.a_operand = $urandom;
    bus.b_operand = $urandom;
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.result !== held) moved = 1'b1;
        bus.start = (mode == 1 && cnt == 4) ? 1'b1 : 1'b0;
        @(negedge clk);
        cnt++;
      end
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_100", name);
      return;
    end
    chk({name, "_result"}, bus.result, got.res);
    chk({name, "_exc"}, {31'd0, bus.Exception}, {31'd0, got.exc});
    chk({name, "_latency"}, cnt, got.lat);
    chk({name, "_hold"}, {31'd0, moved}, 32'd0);
    if (mode == 1) begin
      bus.a_operand = 32'h3F80_0000;
      bus.b_operand = 32'hBF80_0000;
      bus.start     = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({name, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    if (mode == 1) begin
      spurious = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) spurious = 1'b1;
      end
      chk({name, "_ignored_starts"}, {31'd0, spurious}, 32'd0);
      chk({name, "_result_kept"}, bus.result, got.res);
    end
  endtask

  vec_t vecs[13];
  bit   seen_done;

  initial begin
    // expected values derived by hand: truncating, flush-to-zero arithmetic
    vecs[0]  = '{32'h40A0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5};   // 5-2
    vecs[1]  = '{32'h40A0_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 3};   // exact cancel
    vecs[2]  = '{32'h7F80_0000, 32'hC000_0000, 32'h7F80_0000, 1'b1, 1};   // Inf
    vecs[3]  = '{32'h7FC0_0000, 32'h40A0_0000, 32'h7F80_0000, 1'b1, 1};   // NaN
    vecs[4]  = '{32'hC000_0000, 32'h4020_0000, 32'hC090_0000, 1'b0, 4};   // -2-2.5
    vecs[5]  = '{32'h4100_0000, 32'h0000_0001, 32'h4100_0000, 1'b0, 28};  // denormal flush
    vecs[6]  = '{32'h4000_0000, 32'h40A0_0000, 32'hC040_0000, 1'b0, 5};   // 2-5 (swap)
    vecs[7]  = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 3};   // overflow
    vecs[8]  = '{32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 3};   // underflow
    vecs[9]  = '{32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 1'b0, 27};  // 23 left shifts
    vecs[10] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 4};   // 1-(-1)
    vecs[11] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 3};   // 0-0
    vecs[12] = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 28};  // 0-1

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.a_operand = 32'd0;
    bus.b_operand = 32'd0;
`ifdef FP_ADDSUB_OP_EN
    bus.op        = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_exc", {31'd0, bus.Exception}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].lat, 0);
      $display("vec%0d a=%h b=%h result=%h exc=%b", i, vecs[i].a, vecs[i].b, bus.result, bus.Exception);
    end

    // start pulses while busy and during DONE are ignored
    run_vec("busy_start", 32'h4100_0000, 32'h0000_0001, 32'h4100_0000, 1'b0, 28, 1);
    $display("busy_start result=%h", bus.result);

    // asynchronous reset in the middle of ALIGN
    @(negedge clk);
    bus.a_operand = 32'h4100_0000;
    bus.b_operand = 32'h0000_0001;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("align_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 32'd0);
    chk("abort_exc", {31'd0, bus.Exception}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    $display("reset_abort result=%h busy=%b", bus.result, bus.busy);

    // unit still works after an aborted request
    run_vec("post_reset", 32'h40A0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5, 0);
    $display("post_reset result=%h", bus.result);

`ifdef FP_ADDSUB_OP_EN
    bus.op = 1'b1;
    run_vec("op_add", 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 1'b0, 4, 0);
    $display("op_add result=%h", bus.result);
    bus.op = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
